exu_longp_div: RTL and testbench
================================

Name: exu_longp_div

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. It is the long-pipe producer feeding the longp_wbck_i_* port of the EXU write-back arbiter.
- Accepts one operation at a time from the ALU dispatch side via valid/ready.
- Computes the result over `XLEN cycles, then holds a write-back request until the arbiter accepts it.

Parameters:
- None. Widths come from `XLEN and `RFIDX_WIDTH in defines.v.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- div_i_valid  input  1  issue request
- div_i_ready  output  1  divider can accept an issue
- div_i_rs1  input  `XLEN  dividend
- div_i_rs2  input  `XLEN  divisor
- div_i_op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- div_i_rdidx  input  `RFIDX_WIDTH  destination register index
- longp_wbck_o_valid  output  1  write-back request to the arbiter
- longp_wbck_o_ready  input  1  arbiter accepts the write-back
- longp_wbck_o_data  output  `XLEN  result
- longp_wbck_o_rdidx  output  `RFIDX_WIDTH  destination index of the result
- div_busy  output  1  high in CALC or WBCK; used by dispatch for hazard stall

Behaviour:
- States: IDLE, CALC, WBCK. Reset enters IDLE.
- Reset values: longp_wbck_o_valid=0, longp_wbck_o_data=0, longp_wbck_o_rdidx=0, div_busy=0, div_i_ready=1, internal counter=0.
- IDLE:
  - div_i_ready=1.
  - On div_i_valid&div_i_ready in cycle T: latch op, rdidx, operand magnitudes, quotient sign and remainder sign. Go to CALC with counter=0.
- Operand magnitudes:
  - Signed ops (DIV, REM): |rs1|, |rs2| as unsigned `XLEN values; |-2^(XLEN-1)| = 2^(XLEN-1).
  - Unsigned ops: operands used as is.
- CALC:
  - One quotient bit per cycle, MSB first. Shift remainder:dividend left 1; if partial remainder >= divisor, subtract and set the quotient bit.
  - Partial remainder is `XLEN+1 bits wide.
  - Counter increments each cycle. After the cycle with counter=`XLEN-1, go to WBCK.
  - div_i_ready=0.
- WBCK:
  - longp_wbck_o_valid=1, first at cycle T+`XLEN+1 (latency `XLEN+1 from the accept edge).
  - data and rdidx are registered and held stable while valid=1 and ready=0.
  - On valid&ready, go to IDLE; valid drops next cycle. No same-cycle re-accept.
- Sign fix-up (applied registered, before valid rises):
  - Quotient is negated if sign(rs1)^sign(rs2) for DIV.
  - Remainder is negated if sign(rs1) for REM.
- Corner cases (RISC-V mandated; override the computed value):
  - Divisor=0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=-1, DIV/REM): DIV gives 0x80000000, REM gives 0.
  - Corner cases still take the full latency unless the optional feature is enabled.
- div_i_valid while busy is ignored; the issuer must hold it until ready.
- Asynchronous reset mid-CALC or mid-WBCK aborts the operation. Outputs return to reset values immediately; the pending write-back is lost and never presented.
- longp_wbck_o_ready while not in WBCK has no effect.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined:
  - Divide-by-zero and signed-overflow cases skip CALC. State goes IDLE->WBCK directly, with valid at T+1 and the mandated result.
  - Dividend magnitude < divisor magnitude also skips CALC: quotient 0, remainder = rs1.
- Undefined: every operation takes `XLEN+1 cycles.

Test Plan:
- Reset: assert rst_n=0 -> div_i_ready=1, longp_wbck_o_valid=0, div_busy=0.
- DIVU 100/7, rdidx=5, ready tied 1 -> valid at T+33, data=14, rdidx=5; REMU 100/7 -> data=2.
- DIV -7/2 -> data=0xFFFFFFFD (-3). REM -7/2 -> data=0xFFFFFFFF (-1). REM 7/-2 -> data=1.
- DIV 0x80000000/0xFFFFFFFF -> data=0x80000000; REM of the same operands -> data=0. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Backpressure: hold longp_wbck_o_ready=0 for 10 cycles in WBCK -> valid, data and rdidx stable and div_i_ready=0 throughout. Ready=1 -> IDLE next cycle, div_i_ready=1.
- Reset pulse at CALC cycle 12 -> valid never asserts. After release, a new DIVU 9/3 returns 3 with the full latency.

Source files
------------

// File: rtl/exu_longp_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, feeding the long-pipe write-back port.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero, signed overflow and |rs1|<|rs2| skip the iteration.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module exu_longp_div (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    div_i_valid,
    output logic                    div_i_ready,
    input  logic [`XLEN-1:0]        div_i_rs1,
    input  logic [`XLEN-1:0]        div_i_rs2,
    input  logic [1:0]              div_i_op,
    input  logic [`RFIDX_WIDTH-1:0] div_i_rdidx,
    output logic                    longp_wbck_o_valid,
    input  logic                    longp_wbck_o_ready,
    output logic [`XLEN-1:0]        longp_wbck_o_data,
    output logic [`RFIDX_WIDTH-1:0] longp_wbck_o_rdidx,
    output logic                    div_busy,
    output logic [1:0]              o_dbg_state
);
    localparam int XLEN = `XLEN;
    localparam int CW   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WBCK = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and payload stable until that edge, ready never waits on valid.

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_rs1;
    logic              r_is_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic              r_ovf;
    logic              r_valid;
    logic              r_ready;
    logic              r_busy;
    logic [XLEN-1:0]   r_data;
    logic [`RFIDX_WIDTH-1:0] r_rdidx;

    logic              w_signed;
    logic              w_rs1_neg;
    logic              w_rs2_neg;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_dz;
    logic              w_ovf;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic [XLEN-1:0]   w_result;

    assign w_signed  = ~div_i_op[0];
    assign w_rs1_neg = w_signed & div_i_rs1[XLEN-1];
    assign w_rs2_neg = w_signed & div_i_rs2[XLEN-1];
    assign w_mag1    = w_rs1_neg ? (~div_i_rs1 + 1'b1) : div_i_rs1;
    assign w_mag2    = w_rs2_neg ? (~div_i_rs2 + 1'b1) : div_i_rs2;
    assign w_dz      = (div_i_rs2 == '0);
    assign w_ovf     = w_signed & (div_i_rs1 == MIN_NEG) & (div_i_rs2 == '1);

    // The partial remainder is one bit wider than XLEN only after the shift.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_diff    = w_shift[XLEN-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    assign w_q_fix   = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_r_fix   = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    always_comb begin
        w_result = r_is_rem ? w_r_fix : w_q_fix;
        if (r_dz) begin
            w_result = r_is_rem ? r_rs1 : '1;
        end else if (r_ovf) begin
            w_result = r_is_rem ? '0 : MIN_NEG;
        end
    end

`ifdef DIV_FAST_PATH_EN
    logic            w_fast;
    logic [XLEN-1:0] w_fast_result;
    assign w_fast = w_dz | w_ovf | (w_mag1 < w_mag2);
    always_comb begin
        w_fast_result = div_i_op[1] ? div_i_rs1 : '0;
        if (w_dz) begin
            w_fast_result = div_i_op[1] ? div_i_rs1 : '1;
        end else if (w_ovf) begin
            w_fast_result = div_i_op[1] ? '0 : MIN_NEG;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_rs1    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_data   <= '0;
            r_rdidx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_i_valid) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= w_mag1;
                        r_dvs    <= w_mag2;
                        r_rs1    <= div_i_rs1;
                        r_is_rem <= div_i_op[1];
                        r_neg_q  <= ~div_i_op[1] & (w_rs1_neg ^ w_rs2_neg);
                        r_neg_r  <= w_rs1_neg;
                        r_dz     <= w_dz;
                        r_ovf    <= w_ovf;
                        r_rdidx  <= div_i_rdidx;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
`ifdef DIV_FAST_PATH_EN
                        if (w_fast) begin
                            r_state <= S_WBCK;
                            r_valid <= 1'b1;
                            r_data  <= w_fast_result;
                        end else begin
                            r_state <= S_CALC;
                        end
`else
                        r_state  <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= S_WBCK;
                        r_valid <= 1'b1;
                        r_data  <= w_result;
                    end
                end
                S_WBCK: begin
                    if (longp_wbck_o_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_i_ready        = r_ready;
    assign longp_wbck_o_valid = r_valid;
    assign longp_wbck_o_data  = r_data;
    assign longp_wbck_o_rdidx = r_rdidx;
    assign div_busy           = r_busy;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_exu_longp_div.sv
// Self-checking bench for exu_longp_div: directed RV32M cases plus randomized ops against an arithmetic model.
`timescale 1ns/1ps

module tb_exu_longp_div;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
`ifdef DIV_FAST_PATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        div_i_valid;
  logic        div_i_ready;
  logic [31:0] div_i_rs1;
  logic [31:0] div_i_rs2;
  logic [1:0]  div_i_op;
  logic [4:0]  div_i_rdidx;
  logic        longp_wbck_o_valid;
  logic        longp_wbck_o_ready;
  logic [31:0] longp_wbck_o_data;
  logic [4:0]  longp_wbck_o_rdidx;
  logic        div_busy;
  logic [1:0]  dbg_state;

  exu_longp_div dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .div_i_valid        (div_i_valid),
    .div_i_ready        (div_i_ready),
    .div_i_rs1          (div_i_rs1),
    .div_i_rs2          (div_i_rs2),
    .div_i_op           (div_i_op),
    .div_i_rdidx        (div_i_rdidx),
    .longp_wbck_o_valid (longp_wbck_o_valid),
    .longp_wbck_o_ready (longp_wbck_o_ready),
    .longp_wbck_o_data  (longp_wbck_o_data),
    .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
    .div_busy           (div_busy),
    .o_dbg_state        (dbg_state)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [4:0]  rd_q[$];
  int          acc_q[$];
  int          lat_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit junk_en = 1'b0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur within its bound, required it to (t=%0t)", name, $time);
  endtask

  // reference model: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  model = (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN_NEG : 32'($signed(a) / $signed(b));
      OP_DIVU: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit s;
    bit fast;
    logic [31:0] ma, mb;
    s    = !op[0];
    ma   = (s && a[31]) ? -a : a;
    mb   = (s && b[31]) ? -b : b;
    fast = (b == 0) || (s && a == MIN_NEG && b == 32'hFFFF_FFFF) || (ma < mb);
    exp_lat = (FAST_EN && fast) ? 0 : XLEN;
  endfunction

  // compare process: every negedge out of reset
  bit was_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      was_valid = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        chk("valid_without_pending_op", 32'(longp_wbck_o_valid), 32'd0);
      end else if (longp_wbck_o_valid) begin
        if (!was_valid) chk("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
        chk("wbck_data", longp_wbck_o_data, exp_q[0]);
        chk("wbck_rdidx", 32'(longp_wbck_o_rdidx), 32'(rd_q[0]));
        chk("issue_ready_in_wbck", 32'(div_i_ready), 32'd0);
        chk("busy_in_wbck", 32'(div_busy), 32'd1);
        if (longp_wbck_o_ready) begin
          void'(exp_q.pop_front());
          void'(rd_q.pop_front());
          void'(acc_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
      was_valid = longp_wbck_o_valid;
    end
  end

  // driver tasks (called aligned to posedge+#1)
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    int guard;
    int lat;
    guard = 0;
    while (!div_i_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      fail_evt("issue_ready_timeout");
      return;
    end
    div_i_valid = 1'b1;
    div_i_op    = op;
    div_i_rs1   = a;
    div_i_rs2   = b;
    div_i_rdidx = rd;
    lat = exp_lat(op, a, b);
    @(posedge clk); #1;
    exp_q.push_back(exp);
    rd_q.push_back(rd);
    acc_q.push_back(cyc);
    lat_q.push_back(lat);
    // garbage issue requests while busy must be ignored
    if (junk_en && lat >= 16) begin
      repeat ($urandom_range(0, 8)) begin
        div_i_op    = 2'($urandom_range(0, 3));
        div_i_rs1   = $urandom;
        div_i_rs2   = $urandom;
        div_i_rdidx = 5'($urandom_range(0, 31));
        @(posedge clk); #1;
      end
    end
    div_i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk); #1;
      if (rnd_rdy) longp_wbck_o_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    if (guard >= 400) fail_evt("writeback_timeout");
    longp_wbck_o_ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          guard;

    div_i_valid = 1'b0;
    div_i_rs1 = '0;
    div_i_rs2 = '0;
    div_i_op = '0;
    div_i_rdidx = '0;
    longp_wbck_o_ready = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_issue_ready", 32'(div_i_ready), 32'd1);
    chk("reset_valid", 32'(longp_wbck_o_valid), 32'd0);
    chk("reset_busy", 32'(div_busy), 32'd0);
    chk("reset_data", longp_wbck_o_data, 32'd0);
    chk("reset_rdidx", 32'(longp_wbck_o_rdidx), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases with hand-computed results
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
    issue(OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2);
    issue(OP_DIV, -32'sd7, 32'd2, 5'd7, 32'hFFFF_FFFD);
    issue(OP_REM, -32'sd7, 32'd2, 5'd8, 32'hFFFF_FFFF);
    issue(OP_REM, 32'd7, -32'sd2, 5'd9, 32'd1);
    issue(OP_DIV, MIN_NEG, 32'hFFFF_FFFF, 5'd10, MIN_NEG);
    issue(OP_REM, MIN_NEG, 32'hFFFF_FFFF, 5'd11, 32'd0);
    issue(OP_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF);
    issue(OP_REMU, 32'd5, 32'd0, 5'd13, 32'd5);
    issue(OP_DIV, -32'sd5, 32'd0, 5'd14, 32'hFFFF_FFFF);
    issue(OP_REM, -32'sd5, 32'd0, 5'd15, 32'hFFFF_FFFB);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'd3, 32'd10, 5'd1, 32'd0);
    wait_done();

    // backpressure: hold ready low for 10 cycles in write-back
    longp_wbck_o_ready = 1'b0;
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd9, 32'd100);
    guard = 0;
    while (!longp_wbck_o_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) fail_evt("backpressure_valid");
    repeat (10) @(posedge clk);
    #1;
    longp_wbck_o_ready = 1'b1;
    wait_done();
    chk("post_wbck_issue_ready", 32'(div_i_ready), 32'd1);
    chk("post_wbck_valid", 32'(longp_wbck_o_valid), 32'd0);
    chk("post_wbck_busy", 32'(div_busy), 32'd0);

    // reset pulse in the middle of the iteration
    issue(OP_DIVU, 32'd12345, 32'd67, 5'd3, 32'd184);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    rd_q.delete();
    acc_q.delete();
    lat_q.delete();
    #1;
    chk("abort_issue_ready", 32'(div_i_ready), 32'd1);
    chk("abort_valid", 32'(longp_wbck_o_valid), 32'd0);
    chk("abort_busy", 32'(div_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(OP_DIVU, 32'd9, 32'd3, 5'd7, 32'd3);
    wait_done();

    // randomized ops with random write-back backpressure
    junk_en = 1'b1;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        3: b = $urandom_range(0, 15) - 8;
        4: a = $urandom_range(0, 15) - 8;
        default: ;
      endcase
      issue(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b));
      wait_done();
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
